// File: rtl/tlb_ctrl_pkg.sv
// Shared CPU types for the TLB instruction controller: op codes, entry layout, index width.
package tlb_ctrl_pkg;

    localparam int TLB_ENTRIES_NUM = 16;

    typedef logic [$clog2(TLB_ENTRIES_NUM)-1:0] tlb_index_t;

    typedef enum logic [1:0] {
        TLBP  = 2'd0,
        TLBR  = 2'd1,
        TLBWI = 2'd2,
        TLBWR = 2'd3
    } tlb_op_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] pagemask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_ctrl_if.sv
// Bundle of commit-stage, CP0 and TLB-array signals around tlb_ctrl; slave is the controller side.
interface tlb_ctrl_if import tlb_ctrl_pkg::*; #(
    parameter int TLB_ENTRIES = TLB_ENTRIES_NUM
) ();
    localparam int IW = $clog2(TLB_ENTRIES);

    logic             req_valid;
    tlb_op_t          req_op;
    logic             req_ready;
    logic             done;
    logic [31:0]      cp0_index;
    logic [31:0]      cp0_wired;
    logic             cp0_wired_we;
    logic [31:0]      cp0_entry_hi;
    tlb_entry_t       cp0_entry;
    logic [IW-1:0]    tlbrw_index;
    logic             tlbrw_we;
    tlb_entry_t       tlbrw_wdata;
    tlb_entry_t       tlbrw_rdata;
    logic [31:0]      tlbp_entry_hi;
    logic [31:0]      tlbp_index;
    logic             cp0_index_we;
    logic [31:0]      cp0_index_wdata;
    logic             cp0_entry_we;
    tlb_entry_t       cp0_entry_wdata;
    logic [IW-1:0]    cp0_random;

    modport master (
        output req_valid, req_op, cp0_index, cp0_wired, cp0_wired_we, cp0_entry_hi,
               cp0_entry, tlbrw_rdata, tlbp_index,
        input  req_ready, done, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
               cp0_index_we, cp0_index_wdata, cp0_entry_we, cp0_entry_wdata, cp0_random
    );

    modport slave (
        input  req_valid, req_op, cp0_index, cp0_wired, cp0_wired_we, cp0_entry_hi,
               cp0_entry, tlbrw_rdata, tlbp_index,
        output req_ready, done, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
               cp0_index_we, cp0_index_wdata, cp0_entry_we, cp0_entry_wdata, cp0_random
    );
endinterface

// File: rtl/tlb_ctrl_random.sv
// CP0 Random counter: free-running down-counter that wraps from the floor back to TLB_ENTRIES-1.
module tlb_random #(
    parameter int TLB_ENTRIES = 16,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    output logic [IW-1:0] random
);
    localparam logic [IW-1:0] RND_MAX = IW'(TLB_ENTRIES - 1);

    logic [IW-1:0] random_q, random_d;

    // A floor at the top leaves no legal range, so the counter parks at RND_MAX.
    always_comb begin
        random_d = random_q - IW'(1);
        if (wired_we || (random_q == wired) || (wired >= RND_MAX))
            random_d = RND_MAX;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) random_q <= RND_MAX;
        else         random_q <= random_d;
    end

    assign random = random_q;
endmodule

// File: rtl/tlb_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR between CP0 and the TLB array in three cycles per op.
// Optional build macro TLB_CTRL_WIRED_EN: CP0 Wired sets the Random wrap floor.
module tlb_ctrl import tlb_ctrl_pkg::*; #(
    parameter int TLB_ENTRIES = TLB_ENTRIES_NUM,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic     clk,
    input  logic     resetn,
    tlb_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROBE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    tlb_op_t       op_q, op_d;
    logic [31:0]   ehi_q, ehi_d;
    tlb_entry_t    entry_q, entry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   probe_q, probe_d;
    tlb_entry_t    rdata_q, rdata_d;

    logic [IW-1:0] floor_w;
    logic          wired_we_w;
    logic [IW-1:0] random_w;
    logic          unused_bits;

`ifdef TLB_CTRL_WIRED_EN
    assign floor_w     = bus.cp0_wired[IW-1:0];
    assign wired_we_w  = bus.cp0_wired_we;
    assign unused_bits = ^{bus.cp0_index[31:IW], bus.cp0_wired[31:IW]};
`else
    assign floor_w     = '0;
    assign wired_we_w  = 1'b0;
    assign unused_bits = ^{bus.cp0_index[31:IW], bus.cp0_wired, bus.cp0_wired_we};
`endif

    tlb_random #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired    (floor_w),
        .wired_we (wired_we_w),
        .random   (random_w)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ehi_d   = ehi_q;
        entry_d = entry_q;
        idx_d   = idx_q;
        probe_d = probe_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    ehi_d   = bus.cp0_entry_hi;
                    entry_d = bus.cp0_entry;
                    idx_d   = (bus.req_op == TLBWR) ? random_w : bus.cp0_index[IW-1:0];
                    case (bus.req_op)
                        TLBP:    state_d = S_PROBE;
                        TLBR:    state_d = S_READ;
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_PROBE: begin
                probe_d = bus.tlbp_index;
                state_d = S_DONE;
            end
            S_READ: begin
                rdata_d = bus.tlbrw_rdata;
                state_d = S_DONE;
            end
            S_WRITE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= TLBP;
            ehi_q   <= '0;
            entry_q <= '0;
            idx_q   <= '0;
            probe_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ehi_q   <= ehi_d;
            entry_q <= entry_d;
            idx_q   <= idx_d;
            probe_q <= probe_d;
            rdata_q <= rdata_d;
        end
    end

    // Every strobe decodes from the registered state, so reset removes it immediately.
    assign bus.req_ready       = (state_q == S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.tlbrw_we        = (state_q == S_WRITE);
    assign bus.tlbrw_index     = idx_q;
    assign bus.tlbrw_wdata     = entry_q;
    assign bus.tlbp_entry_hi   = ehi_q;
    assign bus.cp0_index_we    = (state_q == S_DONE) && (op_q == TLBP);
    assign bus.cp0_index_wdata = probe_q;
    assign bus.cp0_entry_we    = (state_q == S_DONE) && (op_q == TLBR);
    assign bus.cp0_entry_wdata = rdata_q;
    assign bus.cp0_random      = random_w;
endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: reset, Random sequencing, TLBWI/TLBP/TLBR/TLBWR, reset mid-write.
module tb_tlb_ctrl;
    import tlb_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tlb_ctrl_if #(.TLB_ENTRIES(16)) bus ();

    tlb_ctrl #(.TLB_ENTRIES(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // TLB array stub: entry 3 holds VPN2 0x00ABC; reads return an index-tagged entry.
    function automatic tlb_entry_t rd_entry(input logic [3:0] idx);
        tlb_entry_t e;
        e      = '0;
        e.vpn2 = {15'h0A00, idx};
        e.asid = 8'h40;
        e.pfn0 = {16'hC000, idx};
        e.v0   = 1'b1;
        e.pfn1 = {16'hD000, idx};
        e.d1   = 1'b1;
        return e;
    endfunction

    assign bus.tlbp_index  = (bus.tlbp_entry_hi[31:13] == 19'h00ABC) ? 32'd3 : 32'h8000_0000;
    assign bus.tlbrw_rdata = rd_entry(bus.tlbrw_index);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_pulses(input string tag);
        chk({tag, ".done"},     128'(bus.done), 128'd0);
        chk({tag, ".tlbrw_we"}, 128'(bus.tlbrw_we), 128'd0);
        chk({tag, ".idx_we"},   128'(bus.cp0_index_we), 128'd0);
        chk({tag, ".ent_we"},   128'(bus.cp0_entry_we), 128'd0);
    endtask

    tlb_entry_t e1, e2, exp_r;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = TLBP;
        bus.cp0_index    = '0;
        bus.cp0_wired    = '0;
        bus.cp0_wired_we = 1'b0;
        bus.cp0_entry_hi = '0;
        bus.cp0_entry    = '0;
        e1 = '0; e1.vpn2 = 19'h12345; e1.asid = 8'h5A; e1.pfn0 = 20'hABCDE; e1.v0 = 1'b1;
        e2 = '0; e2.vpn2 = 19'h7FFFF; e2.g = 1'b1; e2.pfn1 = 20'h13579; e2.c1 = 3'd3;

        // Reset release and free-running Random
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst.ready",  128'(bus.req_ready), 128'd1);
        chk("rst.random", 128'(bus.cp0_random), 128'd15);
        chk_idle_pulses("rst");
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("rnd[%0d]", i), 128'(bus.cp0_random), (i == 16) ? 128'd15 : 128'(15 - i));
        end

        // TLBWI with index above range; req_valid stays high in WRITE and must be ignored
        bus.cp0_index = 32'h25; bus.cp0_entry = e1;
        bus.req_op = TLBWI; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_op = TLBR; bus.cp0_entry = '0;
        chk("wi.we",    128'(bus.tlbrw_we), 128'd1);
        chk("wi.index", 128'(bus.tlbrw_index), 128'd5);
        chk("wi.wdata", 128'(bus.tlbrw_wdata), 128'(e1));
        chk("wi.ready", 128'(bus.req_ready), 128'd0);
        chk("wi.done1", 128'(bus.done), 128'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("wi.done",   128'(bus.done), 128'd1);
        chk("wi.we_off", 128'(bus.tlbrw_we), 128'd0);
        chk("wi.idxwe",  128'(bus.cp0_index_we), 128'd0);
        chk("wi.entwe",  128'(bus.cp0_entry_we), 128'd0);
        @(negedge clk);
        chk("wi.ready3", 128'(bus.req_ready), 128'd1);
        chk_idle_pulses("wi.n3");

        // TLBP hit; EntryHi changes after accept and must not disturb the latched value
        bus.cp0_entry_hi = {19'h00ABC, 5'd0, 8'h12};
        bus.req_op = TLBP; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.cp0_entry_hi = 32'hFFFF_E000;
        chk("p.ehi",   128'(bus.tlbp_entry_hi), 128'h00ABC << 13 | 128'h12);
        chk("p.idxwe1", 128'(bus.cp0_index_we), 128'd0);
        @(negedge clk);
        chk("p.idxwe", 128'(bus.cp0_index_we), 128'd1);
        chk("p.hit",   128'(bus.cp0_index_wdata), 128'h0000_0003);
        chk("p.done",  128'(bus.done), 128'd1);
        chk("p.entwe", 128'(bus.cp0_entry_we), 128'd0);
        @(negedge clk);

        // TLBP miss
        bus.cp0_entry_hi = {19'h00ABD, 13'd0};
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pm.idxwe", 128'(bus.cp0_index_we), 128'd1);
        chk("pm.miss",  128'(bus.cp0_index_wdata), 128'h8000_0000);
        @(negedge clk);
        chk("pm.ready", 128'(bus.req_ready), 128'd1);

        // TLBR from index 10
        exp_r = '0; exp_r.vpn2 = 19'h0A00A; exp_r.asid = 8'h40; exp_r.pfn0 = 20'hC000A;
        exp_r.v0 = 1'b1; exp_r.pfn1 = 20'hD000A; exp_r.d1 = 1'b1;
        bus.cp0_index = 32'h0000_000A; bus.req_op = TLBR; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("r.entwe1", 128'(bus.cp0_entry_we), 128'd0);
        chk("r.we",     128'(bus.tlbrw_we), 128'd0);
        @(negedge clk);
        chk("r.entwe", 128'(bus.cp0_entry_we), 128'd1);
        chk("r.data",  128'(bus.cp0_entry_wdata), 128'(exp_r));
        chk("r.idxwe", 128'(bus.cp0_index_we), 128'd0);
        @(negedge clk);

        // Fresh reset so Random is at a known point, then Wired handling
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("w.pre", 128'(bus.cp0_random), 128'd12);
        bus.cp0_wired = 32'd4; bus.cp0_wired_we = 1'b1;
        @(negedge clk);
        bus.cp0_wired_we = 1'b0;
`ifdef TLB_CTRL_WIRED_EN
        chk("w.reload", 128'(bus.cp0_random), 128'd15);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("w.rnd[%0d]", k), 128'(bus.cp0_random), (k == 12) ? 128'd15 : 128'(15 - k));
        end
        repeat (8) @(negedge clk);
`else
        chk("w.ignored", 128'(bus.cp0_random), 128'd11);
        repeat (4) @(negedge clk);
`endif

        // TLBWR takes the Random value sampled at accept
        chk("wr.rnd", 128'(bus.cp0_random), 128'd7);
        bus.cp0_index = 32'd0; bus.cp0_entry = e2;
        bus.req_op = TLBWR; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("wr.we",    128'(bus.tlbrw_we), 128'd1);
        chk("wr.index", 128'(bus.tlbrw_index), 128'd7);
        chk("wr.wdata", 128'(bus.tlbrw_wdata), 128'(e2));
        @(negedge clk);
        chk("wr.done", 128'(bus.done), 128'd1);
        @(negedge clk);

`ifdef TLB_CTRL_WIRED_EN
        bus.cp0_wired = 32'd15; bus.cp0_wired_we = 1'b1;
        @(negedge clk);
        bus.cp0_wired_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("w15[%0d]", k), 128'(bus.cp0_random), 128'd15);
        end
`endif

        // Reset asserted while in WRITE drops the write
        bus.cp0_index = 32'd9; bus.cp0_entry = e1;
        bus.req_op = TLBWI; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rw.we_pre", 128'(bus.tlbrw_we), 128'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rw.ready",  128'(bus.req_ready), 128'd1);
        chk("rw.random", 128'(bus.cp0_random), 128'd15);
        chk_idle_pulses("rw");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rw.after", 128'(bus.req_ready), 128'd1);
        chk_idle_pulses("rw.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
